// File: rtl/step_io_pkg.sv
// Board-level constants shared by the STEP switch-driven labs.
package step_io_pkg;

    localparam int CLK_FREQ_HZ             = 12_000_000;
    localparam int DEBOUNCE_MS             = 20;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int SW_CHANNELS             = 4;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: synchroniser, stability counter, stable level and edge pulses.
module debounce_chan
    import step_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall,
    output logic pulse_next
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_raw};
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Any return to the stable level restarts qualification from zero.
        if (sync != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
                rise_d   = sync;
                fall_d   = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_stable  = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    // Lets the top register the combined change pulse in the same cycle as rise/fall.
    assign pulse_next = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce.sv
// Debounces the STEP board switches into clean levels plus per-channel edge pulses.
module switch_debounce
    import step_io_pkg::*;
#(
    parameter int N               = SW_CHANNELS,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_change
);

    logic [N-1:0] pulse_next;
    logic         change_q, change_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .pulse_next(pulse_next[i])
        );
    end

    always_comb begin
        change_d = |pulse_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) change_q <= 1'b0;
        else        change_q <= change_d;
    end

    assign sw_change = change_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench: a sliding-window reference model predicts every output cycle.
module tb_switch_debounce;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 8;
    localparam int HIST = S + D;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_change;

    switch_debounce #(.N(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sw_raw   (sw_raw),
        .sw_stable(sw_stable),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_change(sw_change)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [N-1:0] stable;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         change;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] hist[$];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_upd;
    exp_t         m_e, c_e;
    bit           armed = 0;
    bit           all_diff;
    int           tests = 0;
    int           fails = 0;

    // Reference: a channel flips once the raw samples taken S..S+D-1 edges ago
    // (what the synchroniser presents over the last D edges) all differ from it.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hist.delete();
            for (int j = 0; j < HIST; j++) hist.push_back('0);
            m_stable = '0;
            exp_q.delete();
            m_e = '0;
            exp_q.push_back(m_e);
            armed = 1;
        end else begin
            hist.push_back(sw_raw);
            if (hist.size() > HIST) void'(hist.pop_front());
            m_upd = '0;
            for (int i = 0; i < N; i++) begin
                all_diff = 1;
                for (int j = 0; j < D; j++)
                    if (hist[j][i] == m_stable[i]) all_diff = 0;
                m_upd[i] = all_diff;
            end
            m_e.rise   = m_upd & ~m_stable;
            m_e.fall   = m_upd & m_stable;
            m_stable   = m_stable ^ m_upd;
            m_e.stable = m_stable;
            m_e.change = |m_upd;
            exp_q.push_back(m_e);
        end
    end

    always @(negedge clk_in) begin
        if (armed) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty t=%0t: no expectation queued for this cycle", $time);
            end else begin
                c_e = exp_q.pop_front();
                if ({sw_stable, sw_rise, sw_fall, sw_change} !== c_e) begin
                    fails++;
                    $display("FAIL outputs t=%0t got stable=%b rise=%b fall=%b change=%b, expected stable=%b rise=%b fall=%b change=%b",
                             $time, sw_stable, sw_rise, sw_fall, sw_change,
                             c_e.stable, c_e.rise, c_e.fall, c_e.change);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    initial begin
        rst_in = 1'b0;
        sw_raw = 4'b1111;
        #1 rst_in = 1'b1;
        // reset with switches held high, then release
        tick(3);
        rst_in = 1'b0;
        tick(15);
        // clean step on channel 0
        sw_raw = 4'b1110; tick(12);
        sw_raw = 4'b1111; tick(12);
        // bounce rejected on channel 2, then a held 1
        sw_raw = 4'b1011; tick(12);
        sw_raw[2] = 1'b1; tick(5);
        sw_raw[2] = 1'b0; tick(1);
        sw_raw[2] = 1'b1; tick(5);
        sw_raw[2] = 1'b0; tick(12);
        sw_raw[2] = 1'b1; tick(12);
        // simultaneous fall on ch1 and rise on ch3
        sw_raw[3] = 1'b0; tick(12);
        sw_raw[1] = 1'b0; sw_raw[3] = 1'b1; tick(12);
        // reset mid-count during a 0->1 qualification
        sw_raw[0] = 1'b0; tick(12);
        sw_raw[0] = 1'b1; tick(7);
        rst_in = 1'b1; tick(2);
        rst_in = 1'b0; tick(14);
        // near-miss of D-1 synchronised cycles, then an exact D-cycle pulse
        sw_raw[1] = ~sw_raw[1]; tick(D - 1);
        sw_raw[1] = ~sw_raw[1]; tick(12);
        sw_raw[1] = ~sw_raw[1]; tick(D);
        sw_raw[1] = ~sw_raw[1]; tick(14);
        // random bouncing, holds and occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)
                sw_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                rst_in = 1'b1; tick($urandom_range(1, 3));
                rst_in = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) tick($urandom_range(5, 20));
            else tick(1);
        end
        tick(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
